mem_access_unit: RTL and testbench

MEM-stage data-memory access controller. It drives loads and stores from the EX/MEM pipeline register onto a req/ack data-memory bus. It stalls the pipeline until the access completes and produces the aligned, extended load result salida_ram_MEM that mem_wb captures. It is the producer side of the MEM→WB data path.

---
 rtl/mem_access_pkg.sv | 51 +++++
 rtl/mem_access_unit_load_extender.sv | 36 +++
 rtl/mem_access_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared types and constants for the MEM-stage data-memory access unit:
//   - state_t     : access FSM states (IDLE, BUSY, DONE)
//   - acc_size_t  : decoded access width (byte / halfword / word)
//   - F3_*        : funct3 encodings for loads and stores
//   - BE_*        : byte-enable patterns for lane 0, shifted by the address
//   - size_of()   : funct3 -> access width (unused codes behave as word)
//   - is_misaligned() : alignment rule for a given width and byte offset
// -----------------------------------------------------------------------------
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic acc_size_t size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_of = SZ_BYTE;
      F3_H, F3_HU: size_of = SZ_HALF;
      default:     size_of = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input acc_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// -----------------------------------------------------------------------------
// load_extender
// Combinational little-endian load lane selection and extension.
// Ports:
//   rdata_i   [31:0] raw word read from the data memory
//   addr_lo_i [1:0]  byte offset of the access inside the word
//   funct3_i  [2:0]  access size/sign (B, H, W, BU, HU; others act as W)
//   result_o  [31:0] sign- or zero-extended load value
// -----------------------------------------------------------------------------
module load_extender
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Byte offset selects the lane; halfwords only ever sit at offset 0 or 2.
  assign byte_lane = rdata_i[8*addr_lo_i +: 8];
  assign half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    case (funct3_i)
      F3_B:    result_o = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   result_o = {24'h000000, byte_lane};
      F3_H:    result_o = {{16{half_lane[15]}}, half_lane};
      F3_HU:   result_o = {16'h0000, half_lane};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data-memory access controller. Launches loads/stores from the
// EX/MEM register onto a req/ack bus, stalls the pipeline while the access is
// outstanding and presents the extended load result for one DONE cycle so
// mem_wb can capture it.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : BUSY aborts after TIMEOUT_CYCLES cycles without mem_ack and
//               pulses bus_error_MEM during the DONE cycle.
//   undefined : BUSY waits indefinitely, bus_error_MEM is tied to 0.
//
// Ports:
//   CLK, RESET_N         clock, asynchronous active-low reset
//   MemRead_MEM          load present in MEM
//   MemWrite_MEM         store present in MEM (wins if both are high)
//   funct3_MEM           access size/sign
//   alu_resultado_MEM    byte address
//   write_data_MEM       store data (rs2)
//   mem_req/we/addr/be/wdata  registered bus request, stable while BUSY
//   mem_rdata, mem_ack   bus response (rdata valid with the one-cycle ack)
//   salida_ram_MEM       extended load result, valid in DONE only
//   stall_MEM            freeze IF..MEM while the access is in flight
//   misaligned_MEM       combinational misaligned-access flag
//   bus_error_MEM        bus timeout flag
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int size           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            MemRead_MEM,
  input  logic            MemWrite_MEM,
  input  logic [2:0]      funct3_MEM,
  input  logic [size-1:0] alu_resultado_MEM,
  input  logic [size-1:0] write_data_MEM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [size-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [size-1:0] mem_wdata,
  input  logic [size-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic [size-1:0] salida_ram_MEM,
  output logic            stall_MEM,
  output logic            misaligned_MEM,
  output logic            bus_error_MEM
);

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [size-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [size-1:0] wdata_q, wdata_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic [size-1:0] salida_q, salida_d;

  logic            access;
  logic            misaligned;
  acc_size_t       acc_size;
  logic [1:0]      off_in;
  logic [3:0]      store_be;
  logic [size-1:0] store_wdata;
  logic [size-1:0] load_result;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             berr_q, berr_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // ---------------------------------------------------------------------------
  // Request decode (only acted upon in IDLE)
  // ---------------------------------------------------------------------------
  assign access     = MemRead_MEM | MemWrite_MEM;
  assign off_in     = alu_resultado_MEM[1:0];
  assign acc_size   = size_of(funct3_MEM);
  assign misaligned = access & is_misaligned(acc_size, off_in);

  always_comb begin
    case (acc_size)
      SZ_BYTE: begin
        store_be    = BE_BYTE << off_in;
        store_wdata = {4{write_data_MEM[7:0]}};
      end
      SZ_HALF: begin
        store_be    = BE_HALF << off_in;
        store_wdata = {2{write_data_MEM[15:0]}};
      end
      default: begin
        store_be    = BE_WORD;
        store_wdata = write_data_MEM;
      end
    endcase
  end

  // Extraction uses the offset/funct3 latched at launch, not the live inputs.
  load_extender u_load_extender (
    .rdata_i   (mem_rdata),
    .addr_lo_i (off_q),
    .funct3_i  (f3_q),
    .result_o  (load_result)
  );

  // ---------------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    off_d     = off_q;
    f3_d      = f3_q;
    salida_d  = salida_q;
    stall_MEM = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
    berr_d    = berr_q;
`endif

    case (state_q)
      IDLE: begin
        if (access && !misaligned) begin
          stall_MEM = 1'b1;
          state_d   = BUSY;
          req_d     = 1'b1;
          we_d      = MemWrite_MEM;
          addr_d    = {alu_resultado_MEM[size-1:2], 2'b00};
          be_d      = MemWrite_MEM ? store_be : BE_WORD;
          wdata_d   = MemWrite_MEM ? store_wdata : '0;
          off_d     = off_in;
          f3_d      = funct3_MEM;
        end
      end

      BUSY: begin
        stall_MEM = 1'b1;
        if (mem_ack) begin
          req_d    = 1'b0;
          salida_d = we_q ? '0 : load_result;
          state_d  = DONE;
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d    = 1'b0;
          salida_d = '0;
          berr_d   = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      DONE: begin
        // Result is held this cycle for mem_wb, then cleared so it never leaks
        // into a later instruction.
        state_d  = IDLE;
        salida_d = '0;
`ifdef MEM_TIMEOUT_EN
        cnt_d    = '0;
        berr_d   = 1'b0;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low reset, so an abort drops mem_req without waiting for a clock.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      wdata_q  <= '0;
      off_q    <= 2'b00;
      f3_q     <= 3'b000;
      salida_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= '0;
      berr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      off_q    <= off_d;
      f3_q     <= f3_d;
      salida_q <= salida_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
      berr_q   <= berr_d;
`endif
    end
  end

  assign mem_req        = req_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_be         = be_q;
  assign mem_wdata      = wdata_q;
  assign salida_ram_MEM = salida_q;
  assign misaligned_MEM = misaligned;
`ifdef MEM_TIMEOUT_EN
  assign bus_error_MEM  = berr_q;
`else
  assign bus_error_MEM  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Scoreboard bench: the driver computes each access's expected bus request and
// result from the load/store rules and queues it; a negedge monitor pops and
// compares whenever the DUT starts, flags or completes an access.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        MemRead_MEM, MemWrite_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] alu_resultado_MEM, write_data_MEM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] salida_ram_MEM;
  logic        stall_MEM, misaligned_MEM, bus_error_MEM;

  always #5 CLK = ~CLK;

  mem_access_unit dut (
    .CLK               (CLK),
    .RESET_N           (RESET_N),
    .MemRead_MEM       (MemRead_MEM),
    .MemWrite_MEM      (MemWrite_MEM),
    .funct3_MEM        (funct3_MEM),
    .alu_resultado_MEM (alu_resultado_MEM),
    .write_data_MEM    (write_data_MEM),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_be            (mem_be),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack),
    .salida_ram_MEM    (salida_ram_MEM),
    .stall_MEM         (stall_MEM),
    .misaligned_MEM    (misaligned_MEM),
    .bus_error_MEM     (bus_error_MEM)
  );

  typedef struct {
    bit          mis;
    bit          we;
    logic [31:0] addr;
    logic [31:0] be;
    logic [31:0] wdata;
    logic [31:0] res;
    int          stall;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model: access width in bytes, offset arithmetic, replication by
  // multiplication and sign extension by subtracting 2^bits.
  function automatic exp_t model(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdata, input int delay);
    exp_t   e;
    int     nbytes, off, bits;
    bit     sgn;
    longint lane, val;
    case (f3)
      3'b000, 3'b100: nbytes = 1;
      3'b001, 3'b101: nbytes = 2;
      default:        nbytes = 4;
    endcase
    sgn   = (f3 == 3'b000) || (f3 == 3'b001);
    off   = int'(addr % 4);
    e.mis = (addr % nbytes) != 0;
    e.we  = wr;
    e.addr = addr - off;
    if (wr) begin
      e.be = (nbytes == 4) ? 32'd15 : (((32'd1 << nbytes) - 1) << off);
      if (nbytes == 1)      e.wdata = (wd % 256) * 32'h01010101;
      else if (nbytes == 2) e.wdata = (wd % 65536) * 32'h00010001;
      else                  e.wdata = wd;
    end else begin
      e.be    = 32'd15;
      e.wdata = 32'd0;
    end
    lane = longint'(rdata >> (8 * off));
    if (nbytes < 4) begin
      bits = 8 * nbytes;
      val  = lane % (longint'(1) << bits);
      if (sgn && val >= (longint'(1) << (bits - 1))) val = val - (longint'(1) << bits);
    end else begin
      val = lane;
    end
    e.res   = (wr || e.mis) ? 32'd0 : val[31:0];
    e.stall = e.mis ? 0 : delay + 2;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  bit   in_access = 0;
  int   cnt = 0;
  exp_t cur;

  task automatic pop_cur(input string name, output bit ok);
    if (q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty when DUT presented an access", name);
      ok = 0;
    end else begin
      cur = q.pop_front();
      ok  = 1;
    end
  endtask

  always @(negedge CLK) begin
    bit ok;
    if (!RESET_N) begin
      check("rst_req", {31'd0, mem_req}, 32'd0);
      check("rst_stall", {31'd0, stall_MEM}, 32'd0);
      check("rst_salida", salida_ram_MEM, 32'd0);
      check("rst_berr", {31'd0, bus_error_MEM}, 32'd0);
      in_access = 0;
    end else if (misaligned_MEM && !in_access) begin
      pop_cur("mis_pop", ok);
      if (ok) begin
        check("mis_flag", {31'd0, misaligned_MEM}, {31'd0, cur.mis});
        check("mis_stall", {31'd0, stall_MEM}, 32'd0);
        check("mis_req", {31'd0, mem_req}, 32'd0);
        check("mis_salida", salida_ram_MEM, 32'd0);
      end
    end else if (in_access) begin
      if (stall_MEM) begin
        cnt++;
        check("busy_req", {31'd0, mem_req}, 32'd1);
        check("busy_we", {31'd0, mem_we}, {31'd0, cur.we});
        check("busy_addr", mem_addr, cur.addr);
        check("busy_be", {28'd0, mem_be}, cur.be);
        if (cur.we) check("busy_wdata", mem_wdata, cur.wdata);
      end else begin
        check("done_stall_cycles", cnt, cur.stall);
        check("done_salida", salida_ram_MEM, cur.res);
        check("done_req", {31'd0, mem_req}, 32'd0);
        check("done_berr", {31'd0, bus_error_MEM}, 32'd0);
        in_access = 0;
      end
    end else if (stall_MEM) begin
      pop_cur("start_pop", ok);
      if (ok) begin
        check("start_mis", {31'd0, misaligned_MEM}, {31'd0, cur.mis});
        check("start_req", {31'd0, mem_req}, 32'd0);
        check("start_salida", salida_ram_MEM, 32'd0);
        in_access = 1;
        cnt = 1;
      end
    end else begin
      check("idle_req", {31'd0, mem_req}, 32'd0);
      check("idle_salida", salida_ram_MEM, 32'd0);
      check("idle_berr", {31'd0, bus_error_MEM}, 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    MemRead_MEM  = 1'b0;
    MemWrite_MEM = 1'b0;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int delay);
    exp_t e;
    int   t;
    e = model(rd, wr, f3, addr, wd, rdata, delay);
    q.push_back(e);
    MemRead_MEM       = rd;
    MemWrite_MEM      = wr;
    funct3_MEM        = f3;
    alu_resultado_MEM = addr;
    write_data_MEM    = wd;
    if (e.mis) begin
      @(posedge CLK); #1;
      idle_inputs();
      return;
    end
    t = 0;
    do begin
      @(posedge CLK); #1;
      t++;
    end while (!mem_req && t < 8);
    if (!mem_req) begin
      check("req_launch_timeout", {31'd0, mem_req}, 32'd1);
      idle_inputs();
      return;
    end
    repeat (delay) begin
      @(posedge CLK); #1;
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(posedge CLK); #1;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    @(posedge CLK); #1;
    idle_inputs();
  endtask

  localparam logic [2:0] F3_LIST [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    int t;
    RESET_N = 1'b0;
    idle_inputs();
    funct3_MEM        = 3'b010;
    alu_resultado_MEM = 32'd0;
    write_data_MEM    = 32'd0;
    mem_rdata         = 32'd0;
    mem_ack           = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    @(posedge CLK); #1;

    // Directed cases
    access(1, 0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0);
    access(1, 0, 3'b000, 32'h0000_0103, 32'h0,         32'h8011_2233, 1);
    access(1, 0, 3'b100, 32'h0000_0103, 32'h0,         32'h8011_2233, 0);
    access(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h1234_5678, 3);
    access(1, 0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,         0);
    access(1, 1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'hFFFF_FFFF, 1);
    access(1, 0, 3'b101, 32'h0000_0402, 32'h0,         32'h8765_4321, 2);
    access(1, 0, 3'b001, 32'h0000_0403, 32'h0,         32'h0,         0);

    // Reset while BUSY, then a late ack that must be ignored
    q.push_back(model(1, 0, 3'b010, 32'h0000_0500, 32'h0, 32'h0, 0));
    MemRead_MEM       = 1'b1;
    funct3_MEM        = 3'b010;
    alu_resultado_MEM = 32'h0000_0500;
    t = 0;
    do begin
      @(posedge CLK); #1;
      t++;
    end while (!mem_req && t < 8);
    check("rst_test_launch", {31'd0, mem_req}, 32'd1);
    RESET_N = 1'b0;
    idle_inputs();
    #1 check("rst_req_drop", {31'd0, mem_req}, 32'd0);
    @(posedge CLK); #1;
    RESET_N   = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    @(posedge CLK); #1;
    mem_ack = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    check("rst_late_ack_req", {31'd0, mem_req}, 32'd0);
    check("rst_late_ack_salida", salida_ram_MEM, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      int          kind;
      bit          rd, wr;
      logic [2:0]  f3;
      kind = int'($urandom_range(0, 3));
      rd   = (kind != 1);
      wr   = (kind == 1) || (kind == 2);
      f3   = F3_LIST[$urandom_range(0, 4)];
      access(rd, wr, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 4)));
      if ($urandom_range(0, 5) == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        @(posedge CLK); #1;
        mem_ack = 1'b0;
      end
    end

    repeat (3) begin
      @(posedge CLK); #1;
    end
    check("scoreboard_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
